// File: rtl/cmp_pkg.sv
// Shared types and constants for the time-shared serial magnitude comparator.
// The verdict encoding treats V_EQ as "equal so far, still undecided".
package cmp_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        V_EQ = 2'd0,
        V_LS = 2'd1,
        V_GT = 2'd2
    } verdict_t;

    // Once a verdict has left V_EQ it is frozen; later nibbles cannot change it.
    function automatic verdict_t resolve_verdict(
        input verdict_t cur,
        input logic     eq,
        input logic     ls,
        input logic     gt
    );
        verdict_t res;
        res = cur;
        if (cur == V_EQ && !eq) begin
            if (gt) begin
                res = V_GT;
            end else if (ls) begin
                res = V_LS;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nibble_cmp4.sv
// Single 4-bit unsigned comparator slice; exactly one of eq/ls/gt is high.
module nibble_cmp4
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                eq,
    output logic                ls,
    output logic                gt
);

    always_comb begin
        eq = (a == b);
        ls = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial multi-nibble magnitude comparator: one shared nibble slice, MS nibble first.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as a nibble decides.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    output logic                      busy,
    output logic                      done,
    output logic                      a_eq_b,
    output logic                      a_ls_b,
    output logic                      a_gt_b
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);

    state_t             state_reg,   state_next;
    logic [CNT_W-1:0]   count_reg,   count_next;
    logic [W-1:0]       a_sh_reg,    a_sh_next;
    logic [W-1:0]       b_sh_reg,    b_sh_next;
    verdict_t           verdict_reg, verdict_next;
    logic               eq_reg,      eq_next;
    logic               ls_reg,      ls_next;
    logic               gt_reg,      gt_next;

    logic               nib_eq, nib_ls, nib_gt;
    verdict_t           verdict_upd;
    logic               run_exit;

    nibble_cmp4 u_slice (
        .a  (a_sh_reg[W-1 -: NIBBLE_W]),
        .b  (b_sh_reg[W-1 -: NIBBLE_W]),
        .eq (nib_eq),
        .ls (nib_ls),
        .gt (nib_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            verdict_reg <= V_EQ;
            eq_reg      <= 1'b0;
            ls_reg      <= 1'b0;
            gt_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            a_sh_reg    <= a_sh_next;
            b_sh_reg    <= b_sh_next;
            verdict_reg <= verdict_next;
            eq_reg      <= eq_next;
            ls_reg      <= ls_next;
            gt_reg      <= gt_next;
        end
    end

    // Verdict including the nibble currently on the slice.
    always_comb begin
        verdict_upd = resolve_verdict(verdict_reg, nib_eq, nib_ls, nib_gt);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        run_exit = (count_reg == '0) || (verdict_upd != V_EQ);
`else
        run_exit = (count_reg == '0);
`endif
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        a_sh_next    = a_sh_reg;
        b_sh_next    = b_sh_reg;
        verdict_next = verdict_reg;
        eq_next      = eq_reg;
        ls_next      = ls_reg;
        gt_next      = gt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next    = a;
                    b_sh_next    = b;
                    count_next   = CNT_W'(NIBBLES - 1);
                    verdict_next = V_EQ;
                    state_next   = RUN;
                end
            end
            RUN: begin
                a_sh_next    = {a_sh_reg[W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
                b_sh_next    = {b_sh_reg[W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
                verdict_next = verdict_upd;
                if (run_exit) begin
                    // Results are loaded on the edge that enters DONE.
                    eq_next    = (verdict_upd == V_EQ);
                    ls_next    = (verdict_upd == V_LS);
                    gt_next    = (verdict_upd == V_GT);
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign a_eq_b = eq_reg;
    assign a_ls_b = ls_reg;
    assign a_gt_b = gt_reg;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl (NIBBLES=4); covers both latency builds.
module tb_serial_cmp_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, a_eq_b, a_ls_b, a_gt_b;

    int compared = 0;
    int mismatched = 0;

    logic hold_eq = 1'b0, hold_ls = 1'b0, hold_gt = 1'b0;

    serial_cmp_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_eq_b (a_eq_b),
        .a_ls_b (a_ls_b),
        .a_gt_b (a_gt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lat(input int full, input int early);
        return EE ? early : full;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic eeq, input logic els, input logic egt, input int exp_lat);
        int seen;
        seen = 0;
        a = av;
        b = bv;
        start = 1'b1;
        for (int c = 1; c <= 12 && seen == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            if (done) begin
                seen = c;
            end else begin
                check({tag, " busy"}, int'(busy), 1);
                check({tag, " hold"}, int'({a_eq_b, a_ls_b, a_gt_b}), int'({hold_eq, hold_ls, hold_gt}));
            end
        end
        check({tag, " latency"}, seen, exp_lat);
        check({tag, " busy@done"}, int'(busy), 1);
        check({tag, " result"}, int'({a_eq_b, a_ls_b, a_gt_b}), int'({eeq, els, egt}));
        hold_eq = eeq;
        hold_ls = els;
        hold_gt = egt;
        @(negedge clk);
        check({tag, " done pulse"}, int'(done), 0);
        check({tag, " busy after"}, int'(busy), 0);
        check({tag, " result kept"}, int'({a_eq_b, a_ls_b, a_gt_b}), int'({eeq, els, egt}));
        $display("txn %s a=%h b=%h eq/ls/gt=%b%b%b done@%0d", tag, av, bv, a_eq_b, a_ls_b, a_gt_b, seen);
    endtask

    initial begin
        int dcount;
        int dcycle;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset results", int'({a_eq_b, a_ls_b, a_gt_b}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle results", int'({a_eq_b, a_ls_b, a_gt_b}), 0);

        run_cmp("eq_1234",   16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 5);
        run_cmp("gt_8000",   16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, lat(5, 2));
        run_cmp("ls_1233",   16'h1233, 16'h1234, 1'b0, 1'b1, 1'b0, 5);
        run_cmp("gt_sticky", 16'h2100, 16'h1F00, 1'b0, 1'b0, 1'b1, lat(5, 2));

        // Re-pulsed start while busy must be ignored
        dcount = 0;
        dcycle = 0;
        a = 16'h1233;
        b = 16'h1234;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = (c >= 2 && c <= 4);
            a = 16'hFFFF;
            b = 16'h0000;
            if (done) begin
                dcount++;
                dcycle = c;
            end
            check("repulse busy", int'(busy), 1);
        end
        check("repulse done count", dcount, 1);
        check("repulse done cycle", dcycle, 5);
        check("repulse result", int'({a_eq_b, a_ls_b, a_gt_b}), 3'b010);
        $display("txn repulse a=1233 b=1234 eq/ls/gt=%b%b%b done@%0d", a_eq_b, a_ls_b, a_gt_b, dcycle);
        hold_eq = 1'b0; hold_ls = 1'b1; hold_gt = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("cycle6 idle", int'(busy), 0);
        check("cycle6 no done", int'(done), 0);
        run_cmp("b2b_gt_ffff", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, lat(5, 2));
        run_cmp("ls_0000",     16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, lat(5, 2));

        // Asynchronous reset in the middle of RUN
        a = 16'h1234;
        b = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst results", int'({a_eq_b, a_ls_b, a_gt_b}), 0);
        $display("txn midrun_reset eq/ls/gt=%b%b%b busy=%b", a_eq_b, a_ls_b, a_gt_b, busy);
        hold_eq = 1'b0; hold_ls = 1'b0; hold_gt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst no done", dcount, 0);
        check("midrst idle", int'(busy), 0);
        run_cmp("after_rst", 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, lat(5, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Sequencing controller that performs a multi-nibble magnitude comparison of two wide operands. It reuses one 4-bit comparator slice and steps it one nibble per clock, most-significant nibble first. The first differing nibble decides the result, and later nibbles cannot override it. The block sits between a requester (start/done handshake) and the shared 4-bit comparator datapath, replacing a chain of cascaded comparator ICs with a single time-shared slice.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 2..16

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request pulse; sampled only in IDLE
a  input  4*NIBBLES  operand A; sampled on the accepted start cycle only
b  input  4*NIBBLES  operand B; sampled on the accepted start cycle only
busy  output  1  high while a comparison is in progress (RUN or DONE)
done  output  1  one-cycle pulse; result outputs are valid and updated this cycle
a_eq_b  output  1  registered result, A == B
a_ls_b  output  1  registered result, A < B
a_gt_b  output  1  registered result, A > B

Behaviour:
- Reset (asynchronous assert): state=IDLE; busy=0, done=0, a_eq_b=0, a_ls_b=0, a_gt_b=0. Shift registers and nibble counter are cleared. Reset during RUN or DONE aborts the comparison with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a and b into internal shift registers, loads counter=NIBBLES-1, sets the provisional verdict to "equal, undecided", and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each cycle compares the top nibbles of the shift registers, then shifts both left by 4 bits.
  - If the verdict is undecided and the nibbles differ, the verdict becomes GT or LS and is sticky.
  - When counter==0, moves to DONE; otherwise the counter decrements.
  - Exactly NIBBLES RUN cycles.
- DONE:
  - done=1 for exactly one cycle.
  - a_eq_b/a_ls_b/a_gt_b are loaded from the verdict on entry to DONE; exactly one of them is high from then on.
  - Always returns to IDLE next cycle.
- Latency: start accepted in cycle 0 → done high in cycle NIBBLES+1. A new start is accepted in the cycle after done (busy low).
- start while busy=1 is ignored, with no queueing. Changes to a/b after acceptance have no effect.
- Result outputs hold their last value until the next DONE and do not change during RUN. Before the first completed comparison they are all 0.
- Comparison is unsigned.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: RUN exits to DONE in the same cycle the verdict first becomes decided, or at counter==0, whichever is first. If the k-th nibble examined (k=1..NIBBLES) decides, done is high in cycle k+1.
- Undefined: fixed latency of NIBBLES+1 in all cases.
- Result values are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - NIBBLE_W=4.
  - State enum {IDLE, RUN, DONE}.
  - Verdict enum {V_EQ, V_LS, V_GT}.
- Sub-module nibble_cmp4: purely combinational 4-bit unsigned comparator with eq/ls/gt outputs, one-hot. Instantiated once and fed with the top nibbles of the shift registers.
- The controller holds the FSM, counter, shift registers, verdict and output registers.

Test Plan (NIBBLES=4):
- a=16'h1234, b=16'h1234, start in cycle 0 → done in cycle 5 (both builds); a_eq_b=1, others 0; busy high in cycles 1-5.
- a=16'h8000, b=16'h7FFF → a_gt_b=1; done in cycle 5 without the macro, cycle 2 with SERIAL_CMP_EARLY_EXIT_EN.
- a=16'h1233, b=16'h1234 → a_ls_b=1; done in cycle 5 in both builds; verify a later-nibble difference never overrides an earlier decision, using a=16'h2100, b=16'h1F00 → a_gt_b=1.
- start re-pulsed in cycles 2-4 with different operands → ignored; single done in cycle 5 with the original result; back-to-back start in cycle 6 is accepted.
- rst asserted mid-RUN (cycle 3) → outputs immediately 0 asynchronously, no done pulse; a fresh start after rst deasserts completes normally.
- a=16'hFFFF, b=16'h0000 then a=0, b=16'hFFFF → gt then ls; outputs stay stable between the two done pulses.
